// File: rtl/cond_logic_bank.sv
// Condition-check unit with one {Q,N,Z,C,V} flag bank per hardware context.
// Evaluates the ARM condition field against the selected bank, gates the
// PC/register/memory write requests, and applies grouped flag updates.
module cond_logic_bank #(
    parameter  int NCTX    = 4,
    parameter  int REG_OUT = 0,
    localparam int CTXW    = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Valid,
    input  logic [CTXW-1:0] CtxSel,
    input  logic [3:0]      Cond,
    input  logic [4:0]      ALUFlags,
    input  logic [1:0]      FlagW,
    input  logic            QSet,
    input  logic            QClr,
    input  logic            CtxClr,
    input  logic            PCS,
    input  logic            RegW,
    input  logic            MemW,
    output logic            CondEx,
    output logic            PCSrc,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic [4:0]      FlagsOut
);

    // Bank bit layout: [4]=Q [3]=N [2]=Z [1]=C [0]=V
    logic [4:0] bank_q [NCTX];
    logic [4:0] bank_d [NCTX];

    logic       sel_hit;
    logic [4:0] sel_flags;
    logic       cond_pass;
    logic       cond_ex_c;
    logic [3:0] gated_c;

    // Bank read mux; an out-of-range CtxSel matches no bank and reads as zero.
    always_comb begin
        sel_hit   = 1'b0;
        sel_flags = 5'b0;
        for (int i = 0; i < NCTX; i++) begin
            if (CtxSel == CTXW'(i)) begin
                sel_hit   = 1'b1;
                sel_flags = bank_q[i];
            end
        end
    end

    // Condition decode against the stored (pre-update) flags.
    always_comb begin
        logic n, z, c, v, ge;
        n  = sel_flags[3];
        z  = sel_flags[2];
        c  = sel_flags[1];
        v  = sel_flags[0];
        ge = (n == v);
        cond_pass = 1'b0;
        case (Cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = ~z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = ~c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = ~n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = ~v;
            4'h8:    cond_pass = c & ~z;
            4'h9:    cond_pass = ~(c & ~z);
            4'hA:    cond_pass = ge;
            4'hB:    cond_pass = ~ge;
            4'hC:    cond_pass = ~z & ge;
            4'hD:    cond_pass = ~(~z & ge);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Gate the write requests with the condition result.
    always_comb begin
        cond_ex_c = Valid & sel_hit & cond_pass;
        gated_c   = {cond_ex_c, PCS & cond_ex_c, RegW & cond_ex_c, MemW & cond_ex_c};
    end

    // Next-state for every bank; only the selected bank can change, and a
    // context clear beats any flag write landing in the same cycle.
    always_comb begin
        for (int i = 0; i < NCTX; i++) begin
            bank_d[i] = bank_q[i];
            if (CtxSel == CTXW'(i)) begin
                if (Valid && CtxClr) begin
                    bank_d[i] = 5'b0;
                end else if (cond_ex_c) begin
                    if (FlagW[1]) bank_d[i][3:2] = ALUFlags[3:2];
                    if (FlagW[0]) bank_d[i][1:0] = ALUFlags[1:0];
                    if (QClr && QSet)  bank_d[i][4] = ALUFlags[4];
                    else if (QClr)     bank_d[i][4] = 1'b0;
                    else if (QSet)     bank_d[i][4] = bank_q[i][4] | ALUFlags[4];
                end
            end
        end
    end

    // Flag bank storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCTX; i++) bank_q[i] <= 5'b0;
        end else begin
            for (int i = 0; i < NCTX; i++) bank_q[i] <= bank_d[i];
        end
    end

    assign FlagsOut = sel_flags;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [3:0] gated_q;
            logic [3:0] gated_d;

            // Reset clears the pipelined outputs on the next edge.
            always_comb gated_d = reset ? 4'b0 : gated_c;

            // One pipeline stage on the gated outputs.
            always_ff @(posedge clk) begin
                gated_q <= gated_d;
            end

            assign {CondEx, PCSrc, RegWrite, MemWrite} = gated_q;
        end else begin : g_comb_out
            assign {CondEx, PCSrc, RegWrite, MemWrite} = gated_c;
        end
    endgenerate

endmodule
